// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
package vend_pkg;

    // Default width of credit, coin value and price
    localparam int CREDIT_W_DEF = 8;

    // Change denominations paid out by the hopper
    localparam int COIN_HI = 5;
    localparam int COIN_LO = 1;

    // Transaction states; encoding is visible on the state output port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

endpackage

// File: rtl/vend_idle_timer.sv
// Inactivity timer: counts sec_tick pulses while enabled and pulses expire
// for one cycle once TIMEOUT_TICKS ticks have been seen since the last clear.
module vend_idle_timer #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sec_tick,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q, expire_d;

    // Next-state of the tick counter; clear wins over counting
    always_comb begin
        count_d  = count_q;
        expire_d = 1'b0;
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (enable && sec_tick) begin
            if (count_q == LAST_CNT) begin
                count_d  = {CNT_W{1'b0}};
                expire_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter and registered expire pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= {CNT_W{1'b0}};
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: credit accumulation, price check, dispense
// motor handshake and one-coin-at-a-time change payout. All outputs are
// registered.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int CREDIT_W      = CREDIT_W_DEF,
    parameter int MAX_CREDIT    = 99,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sec_tick,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_value,
    input  logic                select_valid,
    input  logic [CREDIT_W-1:0] product_price,
    input  logic                cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic                vend_req,
    output logic                change_req,
    output logic                change_sel,
    output logic                coin_reject,
    output logic                alarm,
    output logic [CREDIT_W-1:0] credit,
    output logic [15:0]         sales_total,
    output logic [1:0]          state
);

    localparam logic [CREDIT_W:0]   MAX_EXT   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] HI_VAL    = CREDIT_W'(COIN_HI);
    localparam logic [CREDIT_W-1:0] LO_VAL    = CREDIT_W'(COIN_LO);
    localparam logic [CREDIT_W-1:0] CRED_ZERO = {CREDIT_W{1'b0}};

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [15:0]         sales_q, sales_d;
    logic                vend_req_q, vend_req_d;
    logic                change_req_q, change_req_d;
    logic                change_sel_q, change_sel_d;
    logic                coin_reject_q, coin_reject_d;
    logic                alarm_q, alarm_d;

    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_fits_s;
    logic                price_ok_s;
    logic [16:0]         sales_sum_s;
    logic                change_hi_s;
    logic [CREDIT_W-1:0] change_step_s;
    logic [CREDIT_W-1:0] credit_after_coin_s;
    logic                timer_clear_s;
    logic                timer_enable_s;
    logic                timer_expire_s;

    // Arithmetic is one bit wider than credit so an oversized coin cannot wrap
    // into an apparently valid sum; subtractions are only used behind compares.
    assign coin_sum_s          = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_fits_s         = (coin_sum_s <= MAX_EXT);
    assign price_ok_s          = (product_price != CRED_ZERO) &&
                                 ({1'b0, credit_q} >= {1'b0, product_price});
    assign sales_sum_s         = {1'b0, sales_q} + 17'(product_price);
    assign change_hi_s         = (credit_q >= HI_VAL);
    assign change_step_s       = change_sel_q ? HI_VAL : LO_VAL;
    assign credit_after_coin_s = credit_q - change_step_s;

    // Inactivity counting only runs in CREDIT; any coin or select restarts it
    assign timer_enable_s = (state_q == ST_CREDIT);
    assign timer_clear_s  = (state_q != ST_CREDIT) || coin_valid || select_valid;

    vend_idle_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .sec_tick (sec_tick),
        .clear    (timer_clear_s),
        .enable   (timer_enable_s),
        .expire   (timer_expire_s)
    );

    // Transaction FSM and datapath next-state; event priority cancel > coin > select
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        sales_d       = sales_q;
        vend_req_d    = vend_req_q;
        change_req_d  = change_req_q;
        change_sel_d  = change_sel_q;
        coin_reject_d = 1'b0;
        alarm_d       = alarm_q;

        case (state_q)
            ST_IDLE: begin
                if (cancel) begin
                    // nothing to refund; same-cycle coin/select are dropped
                    state_d = ST_IDLE;
                end else if (coin_valid) begin
                    alarm_d = 1'b0;
                    if (coin_fits_s) begin
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (select_valid) begin
                    alarm_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CREDIT: begin
                if (cancel || (!coin_valid && !select_valid && timer_expire_s)) begin
                    // refund path; a zero credit has nothing to pay out
                    if (credit_q != CRED_ZERO) begin
                        state_d      = ST_CHANGE;
                        change_req_d = 1'b1;
                        change_sel_d = change_hi_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (coin_valid) begin
                    alarm_d = 1'b0;
                    if (coin_fits_s) begin
                        credit_d = coin_sum_s[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (select_valid) begin
                    if (price_ok_s) begin
                        credit_d   = credit_q - product_price;
                        sales_d    = sales_sum_s[16] ? 16'hFFFF : sales_sum_s[15:0];
                        vend_req_d = 1'b1;
                        alarm_d    = 1'b0;
                        state_d    = ST_VEND;
                    end else begin
                        alarm_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CREDIT;
                end
            end

            ST_VEND: begin
                coin_reject_d = coin_valid;
                if (vend_req_q && vend_ack) begin
                    vend_req_d = 1'b0;
                    if (credit_q != CRED_ZERO) begin
                        state_d      = ST_CHANGE;
                        change_req_d = 1'b1;
                        change_sel_d = change_hi_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_VEND;
                end
            end

            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_req_q && change_ack) begin
                    // coin ejected: book it and return the request to zero
                    credit_d     = credit_after_coin_s;
                    change_req_d = 1'b0;
                    change_sel_d = 1'b0;
                    if (credit_after_coin_s == CRED_ZERO) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CHANGE;
                    end
                end else if (!change_req_q) begin
                    // the one-cycle low gap after an ack; re-request if owed
                    if (credit_q != CRED_ZERO) begin
                        change_req_d = 1'b1;
                        change_sel_d = change_hi_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CHANGE;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                vend_req_d   = 1'b0;
                change_req_d = 1'b0;
                change_sel_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops all requests immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            credit_q      <= {CREDIT_W{1'b0}};
            sales_q       <= 16'h0000;
            vend_req_q    <= 1'b0;
            change_req_q  <= 1'b0;
            change_sel_q  <= 1'b0;
            coin_reject_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            sales_q       <= sales_d;
            vend_req_q    <= vend_req_d;
            change_req_q  <= change_req_d;
            change_sel_q  <= change_sel_d;
            coin_reject_q <= coin_reject_d;
            alarm_q       <= alarm_d;
        end
    end

    assign vend_req    = vend_req_q;
    assign change_req  = change_req_q;
    assign change_sel  = change_sel_q;
    assign coin_reject = coin_reject_q;
    assign alarm       = alarm_q;
    assign credit      = credit_q;
    assign sales_total = sales_q;
    assign state       = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer.
module tb_vend_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sec_tick;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        select_valid;
    logic [7:0]  product_price;
    logic        cancel;
    logic        vend_ack;
    logic        change_ack;
    logic        vend_req;
    logic        change_req;
    logic        change_sel;
    logic        coin_reject;
    logic        alarm;
    logic [7:0]  credit;
    logic [15:0] sales_total;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    vend_sequencer #(
        .CREDIT_W      (8),
        .MAX_CREDIT    (99),
        .TIMEOUT_TICKS (30)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sec_tick      (sec_tick),
        .coin_valid    (coin_valid),
        .coin_value    (coin_value),
        .select_valid  (select_valid),
        .product_price (product_price),
        .cancel        (cancel),
        .vend_ack      (vend_ack),
        .change_ack    (change_ack),
        .vend_req      (vend_req),
        .change_req    (change_req),
        .change_sel    (change_sel),
        .coin_reject   (coin_reject),
        .alarm         (alarm),
        .credit        (credit),
        .sales_total   (sales_total),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [7:0] v);
        coin_valid = 1'b1; coin_value = v;
        step();
        coin_valid = 1'b0; coin_value = 8'd0;
    endtask

    task automatic press_select(input logic [7:0] p);
        select_valid = 1'b1; product_price = p;
        step();
        select_valid = 1'b0; product_price = 8'd0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        step();
    endtask

    // Hopper model: wait (bounded) for change_req, record sel, ack for one cycle
    task automatic hopper_coin(output logic got, output logic sel, output int waits);
        got = 1'b0; sel = 1'b0; waits = 0;
        while (!got && waits < 20) begin
            if (change_req === 1'b1) got = 1'b1;
            else begin step(); waits++; end
        end
        if (got) begin
            sel = change_sel;
            change_ack = 1'b1;
            step();
            change_ack = 1'b0;
        end
    endtask

    // Pay out everything owed, tallying denominations and handshake gaps
    task automatic drain(output int hi, output int lo, output int bad_gap,
                         output int order_err, output int stuck);
        logic got, sel;
        int   w;
        hi = 0; lo = 0; bad_gap = 0; order_err = 0; stuck = 0;
        for (int k = 0; k < 40; k++) begin
            if (state != 2'd3) break;
            hopper_coin(got, sel, w);
            if (!got) begin stuck++; break; end
            if ((k == 0 && w != 0) || (k > 0 && w != 1)) bad_gap++;
            if (sel) begin
                if (lo != 0) order_err++;
                hi++;
            end else begin
                lo++;
            end
        end
        if (state == 2'd3) stuck++;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; sec_tick = 1'b0; coin_valid = 1'b0; coin_value = 8'd0;
        select_valid = 1'b0; product_price = 8'd0; cancel = 1'b0;
        vend_ack = 1'b0; change_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({vend_req, change_req, change_sel, coin_reject, alarm} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b, expected 00000", {vend_req, change_req, change_sel, coin_reject, alarm}); end
        n_cmp++; if ({credit, sales_total, state} !== 26'd0) begin n_err++; $display("FAIL reset_values: credit=%0d sales=%0d state=%0d, expected all 0", credit, sales_total, state); end
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (state !== 2'd0 || credit !== 8'd0) begin n_err++; $display("FAIL reset_release: state=%0d credit=%0d, expected 0/0", state, credit); end
    endtask

    task automatic test_vend_with_change();
        int hi, lo, gap, ord, stk;
        put_coin(8'd5);
        n_cmp++; if (credit !== 8'd5) begin n_err++; $display("FAIL vend_coin1: credit %0d, expected 5", credit); end
        put_coin(8'd5);
        put_coin(8'd2);
        n_cmp++; if (credit !== 8'd12 || state !== 2'd1) begin n_err++; $display("FAIL vend_credit12: credit %0d state %0d, expected 12/1", credit, state); end
        press_select(8'd10);
        n_cmp++; if (vend_req !== 1'b1 || state !== 2'd2) begin n_err++; $display("FAIL vend_req_rise: vend_req %b state %0d, expected 1/2", vend_req, state); end
        n_cmp++; if (credit !== 8'd2 || sales_total !== 16'd10) begin n_err++; $display("FAIL vend_books: credit %0d sales %0d, expected 2/10", credit, sales_total); end
        put_coin(8'd1);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd2) begin n_err++; $display("FAIL vend_coin_reject: reject %b credit %0d, expected 1/2", coin_reject, credit); end
        step();
        n_cmp++; if (coin_reject !== 1'b0 || vend_req !== 1'b1) begin n_err++; $display("FAIL vend_hold: reject %b vend_req %b, expected 0/1", coin_reject, vend_req); end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        n_cmp++; if (vend_req !== 1'b0 || change_req !== 1'b1 || state !== 2'd3) begin n_err++; $display("FAIL vend_to_change: vend_req %b change_req %b state %0d, expected 0/1/3", vend_req, change_req, state); end
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 0 || lo !== 2) begin n_err++; $display("FAIL vend_change_coins: hi %0d lo %0d, expected 0/2", hi, lo); end
        n_cmp++; if (gap !== 0 || stk !== 0) begin n_err++; $display("FAIL vend_change_handshake: bad gaps %0d stuck %0d, expected 0/0", gap, stk); end
        n_cmp++; if (credit !== 8'd0 || state !== 2'd0 || change_req !== 1'b0) begin n_err++; $display("FAIL vend_end: credit %0d state %0d change_req %b, expected 0/0/0", credit, state, change_req); end
    endtask

    task automatic test_alarm();
        int hi, lo, gap, ord, stk;
        press_select(8'd5);
        n_cmp++; if (alarm !== 1'b1 || state !== 2'd0) begin n_err++; $display("FAIL alarm_idle_select: alarm %b state %0d, expected 1/0", alarm, state); end
        put_coin(8'd3);
        n_cmp++; if (alarm !== 1'b0 || credit !== 8'd3) begin n_err++; $display("FAIL alarm_cleared_by_coin: alarm %b credit %0d, expected 0/3", alarm, credit); end
        press_select(8'd7);
        n_cmp++; if (alarm !== 1'b1 || state !== 2'd1 || credit !== 8'd3 || vend_req !== 1'b0) begin n_err++; $display("FAIL alarm_short_credit: alarm %b state %0d credit %0d vend_req %b, expected 1/1/3/0", alarm, state, credit, vend_req); end
        put_coin(8'd5);
        n_cmp++; if (alarm !== 1'b0 || credit !== 8'd8) begin n_err++; $display("FAIL alarm_then_coin: alarm %b credit %0d, expected 0/8", alarm, credit); end
        press_select(8'd0);
        n_cmp++; if (alarm !== 1'b1 || state !== 2'd1 || credit !== 8'd8) begin n_err++; $display("FAIL alarm_zero_price: alarm %b state %0d credit %0d, expected 1/1/8", alarm, state, credit); end
        press_cancel();
        n_cmp++; if (change_req !== 1'b1 || change_sel !== 1'b1) begin n_err++; $display("FAIL alarm_refund_start: change_req %b sel %b, expected 1/1", change_req, change_sel); end
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 1 || lo !== 3 || gap !== 0 || stk !== 0) begin n_err++; $display("FAIL alarm_refund: hi %0d lo %0d gaps %0d stuck %0d, expected 1/3/0/0", hi, lo, gap, stk); end
        vend_ack = 1'b1; change_ack = 1'b1;
        step(); step();
        vend_ack = 1'b0; change_ack = 1'b0;
        n_cmp++; if (state !== 2'd0 || credit !== 8'd0 || vend_req !== 1'b0 || change_req !== 1'b0) begin n_err++; $display("FAIL stray_ack: state %0d credit %0d reqs %b%b, expected 0/0/00", state, credit, vend_req, change_req); end
    endtask

    task automatic test_reject_refund();
        int hi, lo, gap, ord, stk;
        put_coin(8'd50);
        put_coin(8'd47);
        n_cmp++; if (credit !== 8'd97) begin n_err++; $display("FAIL rej_credit97: credit %0d, expected 97", credit); end
        put_coin(8'd5);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd97) begin n_err++; $display("FAIL rej_over_max: reject %b credit %0d, expected 1/97", coin_reject, credit); end
        step();
        n_cmp++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL rej_pulse_width: reject %b, expected 0", coin_reject); end
        put_coin(8'd255);
        n_cmp++; if (coin_reject !== 1'b1 || credit !== 8'd97) begin n_err++; $display("FAIL rej_wrap_coin: reject %b credit %0d, expected 1/97", coin_reject, credit); end
        press_cancel();
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 19 || lo !== 2) begin n_err++; $display("FAIL rej_refund_coins: hi %0d lo %0d, expected 19/2", hi, lo); end
        n_cmp++; if (gap !== 0 || ord !== 0 || stk !== 0) begin n_err++; $display("FAIL rej_refund_handshake: gaps %0d order %0d stuck %0d, expected 0/0/0", gap, ord, stk); end
        n_cmp++; if (credit !== 8'd0 || state !== 2'd0) begin n_err++; $display("FAIL rej_end: credit %0d state %0d, expected 0/0", credit, state); end
    endtask

    task automatic test_timeout();
        int hi, lo, gap, ord, stk;
        put_coin(8'd5);
        put_coin(8'd1);
        for (int i = 0; i < 29; i++) tick();
        n_cmp++; if (state !== 2'd1 || credit !== 8'd6) begin n_err++; $display("FAIL to_29_ticks: state %0d credit %0d, expected 1/6", state, credit); end
        tick();
        for (int i = 0; i < 5 && state != 2'd3; i++) step();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL to_30_ticks: state %0d, expected 3", state); end
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 1 || lo !== 1 || stk !== 0 || state !== 2'd0) begin n_err++; $display("FAIL to_refund: hi %0d lo %0d stuck %0d state %0d, expected 1/1/0/0", hi, lo, stk, state); end
        put_coin(8'd5);
        put_coin(8'd1);
        for (int i = 0; i < 28; i++) tick();
        put_coin(8'd1);
        for (int i = 0; i < 29; i++) tick();
        n_cmp++; if (state !== 2'd1 || credit !== 8'd7) begin n_err++; $display("FAIL to_restart: state %0d credit %0d, expected 1/7", state, credit); end
        tick();
        for (int i = 0; i < 5 && state != 2'd3; i++) step();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL to_restart_expire: state %0d, expected 3", state); end
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 1 || lo !== 2 || stk !== 0 || state !== 2'd0) begin n_err++; $display("FAIL to_restart_refund: hi %0d lo %0d stuck %0d state %0d, expected 1/2/0/0", hi, lo, stk, state); end
    endtask

    task automatic test_simultaneous();
        int hi, lo, gap, ord, stk;
        press_cancel();
        n_cmp++; if (state !== 2'd0 || change_req !== 1'b0) begin n_err++; $display("FAIL sim_idle_cancel: state %0d change_req %b, expected 0/0", state, change_req); end
        put_coin(8'd4);
        coin_valid = 1'b1; coin_value = 8'd2; select_valid = 1'b1; product_price = 8'd1;
        step();
        coin_valid = 1'b0; coin_value = 8'd0; select_valid = 1'b0; product_price = 8'd0;
        n_cmp++; if (credit !== 8'd6 || vend_req !== 1'b0 || state !== 2'd1 || sales_total !== 16'd10) begin n_err++; $display("FAIL sim_coin_over_select: credit %0d vend_req %b state %0d sales %0d, expected 6/0/1/10", credit, vend_req, state, sales_total); end
        cancel = 1'b1; coin_valid = 1'b1; coin_value = 8'd3;
        step();
        cancel = 1'b0; coin_valid = 1'b0; coin_value = 8'd0;
        n_cmp++; if (state !== 2'd3 || credit !== 8'd6 || coin_reject !== 1'b0) begin n_err++; $display("FAIL sim_cancel_over_coin: state %0d credit %0d reject %b, expected 3/6/0", state, credit, coin_reject); end
        drain(hi, lo, gap, ord, stk);
        n_cmp++; if (hi !== 1 || lo !== 1 || stk !== 0 || state !== 2'd0) begin n_err++; $display("FAIL sim_refund: hi %0d lo %0d stuck %0d state %0d, expected 1/1/0/0", hi, lo, stk, state); end
    endtask

    task automatic test_reset_mid_vend();
        put_coin(8'd99);
        n_cmp++; if (credit !== 8'd99 || coin_reject !== 1'b0) begin n_err++; $display("FAIL rst_max_coin: credit %0d reject %b, expected 99/0", credit, coin_reject); end
        press_select(8'd99);
        n_cmp++; if (credit !== 8'd0 || vend_req !== 1'b1 || sales_total !== 16'd109) begin n_err++; $display("FAIL rst_exact_price: credit %0d vend_req %b sales %0d, expected 0/1/109", credit, vend_req, sales_total); end
        vend_ack = 1'b1;
        step();
        vend_ack = 1'b0;
        n_cmp++; if (state !== 2'd0 || vend_req !== 1'b0 || change_req !== 1'b0) begin n_err++; $display("FAIL rst_vend_no_change: state %0d vend_req %b change_req %b, expected 0/0/0", state, vend_req, change_req); end
        put_coin(8'd60);
        press_select(8'd40);
        n_cmp++; if (vend_req !== 1'b1 || credit !== 8'd20 || sales_total !== 16'd149) begin n_err++; $display("FAIL rst_second_vend: vend_req %b credit %0d sales %0d, expected 1/20/149", vend_req, credit, sales_total); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({vend_req, change_req, change_sel, coin_reject, alarm} !== 5'b0) begin n_err++; $display("FAIL rst_async_flags: got %b, expected 00000", {vend_req, change_req, change_sel, coin_reject, alarm}); end
        n_cmp++; if (credit !== 8'd0 || sales_total !== 16'd0 || state !== 2'd0) begin n_err++; $display("FAIL rst_async_values: credit %0d sales %0d state %0d, expected 0/0/0", credit, sales_total, state); end
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (state !== 2'd0 || vend_req !== 1'b0) begin n_err++; $display("FAIL rst_after_release: state %0d vend_req %b, expected 0/0", state, vend_req); end
    endtask

    initial begin
        test_reset();
        test_vend_with_change();
        test_alarm();
        test_reject_refund();
        test_timeout();
        test_simultaneous();
        test_reset_mid_vend();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
